// File: rtl/i2c_slave_if.sv
// i2c_slave_if: pad-level SCL/SDA lines plus the local byte handshake of i2c_slave.
// Latency: none, this is wiring only.
// Backpressure: none here; tx_valid is the only stall input and matters only with stretching.
interface i2c_slave_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       scl_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, tx_data, tx_valid,
    output sda_oe, scl_oe, rx_data, rx_valid, tx_req, busy
  );

  modport master (
    output scl_in, sda_in, tx_data, tx_valid,
    input  sda_oe, scl_oe, rx_data, rx_valid, tx_req, busy
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target; oversampled START/STOP detect, 7-bit address match, byte write/read.
// Latency: pad edges act SYNC_FF+1 clk late; sda_oe/scl_oe drop on the START/STOP clk itself.
// Backpressure: none on writes; reads stall on tx_valid via SCL stretch only with I2C_SLV_STRETCH_EN.
module i2c_slave #(
  parameter logic [6:0] OWN_ADDR = 7'h50,
  parameter int         SYNC_FF  = 2
) (
  input  logic       clk,
  input  logic       reset,
  i2c_slave_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
    S_RD_DATA, S_RD_ACK, S_IGNORE, S_STRETCH
  } state_t;

  logic [SYNC_FF-1:0] r_scl_sync, r_sda_sync;
  logic               r_scl_d, r_sda_d;
  logic               w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_done, w_done_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_scl_oe, w_scl_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       w_load;

  // Synchronize the pads; reset to the idle-high level so reset creates no false edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_FF-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_FF-2:0], bus.sda_in};
      r_scl_d    <= r_scl_sync[SYNC_FF-1];
      r_sda_d    <= r_sda_sync[SYNC_FF-1];
    end
  end

  assign w_scl      = r_scl_sync[SYNC_FF-1];
  assign w_sda      = r_sda_sync[SYNC_FF-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SDA moving while SCL is high is always START/STOP; there is no glitch filter.
  assign w_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign w_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

  // State and datapath registers; everything returns to idle on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_scl_oe   <= w_scl_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
    end
  end

  // Next-state logic: START/STOP win over every state, otherwise step on SCL edges.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = r_done;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_scl_oe_nxt   = 1'b0;
    w_busy_nxt     = r_busy;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_load         = 1'b0;
    if (w_start || w_stop) begin
      w_state_nxt  = w_start ? S_ADDR : S_IDLE;
      w_cnt_nxt    = '0;
      w_done_nxt   = 1'b0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 3'd1;
            w_done_nxt  = (r_cnt == 3'd7);
          end else if (w_scl_fall && r_done) begin
            w_done_nxt = 1'b0;
            if (r_shift[7:1] == OWN_ADDR) begin
              w_state_nxt  = S_ADDR_ACK;
              w_sda_oe_nxt = 1'b1;
              w_busy_nxt   = 1'b1;
              w_rw_nxt     = r_shift[0];
            end else begin
              w_state_nxt = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_rise && r_rw) begin
            w_tx_req_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            if (r_rw) w_load = 1'b1;
            else      w_state_nxt = S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              w_rx_data_nxt  = {r_shift[6:0], w_sda};
              w_rx_valid_nxt = 1'b1;
              w_done_nxt     = 1'b1;
            end
          end else if (w_scl_fall && r_done) begin
            w_done_nxt   = 1'b0;
            w_sda_oe_nxt = 1'b1;
            w_state_nxt  = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_state_nxt  = S_WR_DATA;
          end
        end
        S_RD_DATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = '0;
              w_state_nxt  = S_RD_ACK;
            end else begin
              w_cnt_nxt    = r_cnt + 3'd1;
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_tx_req_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IGNORE;
              w_busy_nxt  = 1'b0;
            end
          end else if (w_scl_fall) begin
            w_load = 1'b1;
          end
        end
`ifdef I2C_SLV_STRETCH_EN
        S_STRETCH: begin
          // scl_oe stays up on the load clk and drops one clk later, after bit7 is on SDA.
          w_scl_oe_nxt = 1'b1;
          if (bus.tx_valid) begin
            w_shift_nxt  = bus.tx_data;
            w_sda_oe_nxt = ~bus.tx_data[7];
            w_cnt_nxt    = '0;
            w_state_nxt  = S_RD_DATA;
          end
        end
`endif
        default: ;
      endcase

      if (w_load) begin
`ifdef I2C_SLV_STRETCH_EN
        if (!bus.tx_valid) begin
          w_scl_oe_nxt = 1'b1;
          w_sda_oe_nxt = 1'b0;
          w_state_nxt  = S_STRETCH;
        end else
`endif
        begin
          w_shift_nxt  = bus.tx_data;
          w_sda_oe_nxt = ~bus.tx_data[7];
          w_cnt_nxt    = '0;
          w_state_nxt  = S_RD_DATA;
        end
      end
    end
  end

  assign bus.sda_oe   = r_sda_oe & ~(w_start | w_stop);
`ifdef I2C_SLV_STRETCH_EN
  assign bus.scl_oe   = r_scl_oe & ~(w_start | w_stop);
`else
  assign bus.scl_oe   = 1'b0;
`endif
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_req   = r_tx_req;
  assign bus.busy     = r_busy;

endmodule
